// File: rtl/apb_master_bridge_if.sv
// rtl/apb_master_bridge_if.sv - APB bus bundle between the bridge and its two slaves
//
// Purpose : carries the APB signals for a master driving two slaves
//           that share paddr/pwrite/pwdata/penable and have separate
//           select, ready, error and read-data lines.
// Modports: master - drives psel1/psel2/penable/paddr/pwrite/pwdata,
//                    receives prdata1/2, pready1/2, pslverr1/2
//           slave  - the mirror image, used by slave models
interface apb_master_bridge_if #(
  parameter int AW = 9,
  parameter int DW = 8
);
  logic          psel1;
  logic          psel2;
  logic          penable;
  logic [AW-1:0] paddr;
  logic          pwrite;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata1;
  logic [DW-1:0] prdata2;
  logic          pready1;
  logic          pready2;
  logic          pslverr1;
  logic          pslverr2;

  modport master (
    output psel1, psel2, penable, paddr, pwrite, pwdata,
    input  prdata1, prdata2, pready1, pready2, pslverr1, pslverr2
  );

  modport slave (
    input  psel1, psel2, penable, paddr, pwrite, pwdata,
    output prdata1, prdata2, pready1, pready2, pslverr1, pslverr2
  );
endinterface

// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - APB master FSM bridging a request port to two APB slaves
//
// Purpose : turns each requested transfer into an APB SETUP/ACCESS pair
//           toward slave1 (paddr[AW-1] = 0) or slave2 (paddr[AW-1] = 1),
//           returns read data and completion status, and forces an error
//           completion when the selected slave holds pready low for
//           TIMEOUT ACCESS cycles.
// Ports   : pclk              - clock, rising edge
//           presetn           - synchronous reset, active HIGH
//           transfer          - request strobe (level)
//           read_write        - 1 = read, 0 = write
//           apb_write_paddr   - write address
//           apb_write_data    - write data
//           apb_read_paddr    - read address
//           apb_read_data_out - data of the last completed read
//           transfer_done     - one-cycle pulse per completion
//           pslverr_out       - status of the last completion (1 = error)
//           bus               - APB master side (see apb_master_bridge_if)
module apb_master_bridge #(
  parameter int AW      = 9,
  parameter int DW      = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                    pclk,
  input  logic                    presetn,
  input  logic                    transfer,
  input  logic                    read_write,
  input  logic [AW-1:0]           apb_write_paddr,
  input  logic [DW-1:0]           apb_write_data,
  input  logic [AW-1:0]           apb_read_paddr,
  output logic [DW-1:0]           apb_read_data_out,
  output logic                    transfer_done,
  output logic                    pslverr_out,
  apb_master_bridge_if.master     bus
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;

  logic          psel1_q;
  logic          psel2_q;
  logic          penable_q;
  logic [AW-1:0] paddr_q;
  logic          pwrite_q;
  logic [DW-1:0] pwdata_q;
  logic [DW-1:0] rdata_q;
  logic          done_q;
  logic          err_q;

  logic          sel_ready;
  logic          sel_err;
  logic [DW-1:0] sel_prdata;
  logic [AW-1:0] req_addr;
  logic          complete;
  logic          accept;

  // Only the slave we actually selected may influence completion;
  // psel2_q is stable for the whole ACCESS phase so it is a safe mux select.
  always_comb begin
    sel_ready  = psel2_q ? bus.pready2  : bus.pready1;
    sel_err    = psel2_q ? bus.pslverr2 : bus.pslverr1;
    sel_prdata = psel2_q ? bus.prdata2  : bus.prdata1;
  end

  assign req_addr = read_write ? apb_read_paddr : apb_write_paddr;
  assign complete = (state == ACCESS) && (sel_ready || (wait_cnt == LAST_WAIT));
  // A new request is taken from IDLE or on the completing ACCESS cycle,
  // which gives back-to-back transfers with no IDLE gap.
  assign accept   = transfer && ((state == IDLE) || complete);

  always_ff @(posedge pclk) begin
    if (presetn) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      psel1_q   <= 1'b0;
      psel2_q   <= 1'b0;
      penable_q <= 1'b0;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      rdata_q   <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;

      unique case (state)
        IDLE: begin
          psel1_q   <= 1'b0;
          psel2_q   <= 1'b0;
          penable_q <= 1'b0;
        end

        SETUP: begin
          penable_q <= 1'b1;
          wait_cnt  <= '0;
          state     <= ACCESS;
        end

        ACCESS: begin
          if (complete) begin
            done_q <= 1'b1;
            // A real pready wins over a simultaneous timeout.
            err_q  <= sel_ready ? sel_err : 1'b1;
            if (sel_ready && !pwrite_q) begin
              rdata_q <= sel_prdata;
            end
            state     <= IDLE;
            psel1_q   <= 1'b0;
            psel2_q   <= 1'b0;
            penable_q <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase

      // Request capture overrides the IDLE/return-to-IDLE assignments above.
      if (accept) begin
        state     <= SETUP;
        pwrite_q  <= ~read_write;
        paddr_q   <= req_addr;
        if (!read_write) begin
          pwdata_q <= apb_write_data;
        end
        psel1_q   <= ~req_addr[AW-1];
        psel2_q   <= req_addr[AW-1];
        penable_q <= 1'b0;
      end
    end
  end

  assign bus.psel1         = psel1_q;
  assign bus.psel2         = psel2_q;
  assign bus.penable       = penable_q;
  assign bus.paddr         = paddr_q;
  assign bus.pwrite        = pwrite_q;
  assign bus.pwdata        = pwdata_q;
  assign apb_read_data_out = rdata_q;
  assign transfer_done     = done_q;
  assign pslverr_out       = err_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb/tb_apb_master_bridge.sv - directed table-driven bench for apb_master_bridge
module tb_apb_master_bridge;

  localparam int AW = 9;
  localparam int DW = 8;
  localparam int TIMEOUT = 16;

  logic          pclk;
  logic          presetn;
  logic          transfer;
  logic          read_write;
  logic [AW-1:0] apb_write_paddr;
  logic [DW-1:0] apb_write_data;
  logic [AW-1:0] apb_read_paddr;
  logic [DW-1:0] apb_read_data_out;
  logic          transfer_done;
  logic          pslverr_out;

  apb_master_bridge_if #(.AW(AW), .DW(DW)) bus ();

  apb_master_bridge #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .pclk              (pclk),
    .presetn           (presetn),
    .transfer          (transfer),
    .read_write        (read_write),
    .apb_write_paddr   (apb_write_paddr),
    .apb_write_data    (apb_write_data),
    .apb_read_paddr    (apb_read_paddr),
    .apb_read_data_out (apb_read_data_out),
    .transfer_done     (transfer_done),
    .pslverr_out       (pslverr_out),
    .bus               (bus.master)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  typedef struct {
    logic          tr;
    logic          rw;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [AW-1:0] ra;
    logic          r1;
    logic          r2;
    logic          e1;
    logic          e2;
    logic [DW-1:0] d1;
    logic [DW-1:0] d2;
    logic          x_s1;
    logic          x_s2;
    logic          x_en;
    logic [AW-1:0] x_pa;
    logic          x_pw;
    logic [DW-1:0] x_wd;
    logic          x_dn;
    logic          x_er;
    logic [DW-1:0] x_rd;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t v(
    input logic tr, rw, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
    input logic [AW-1:0] ra, input logic r1, r2, e1, e2,
    input logic [DW-1:0] d1, d2,
    input logic s1, s2, en, input logic [AW-1:0] pa, input logic pw,
    input logic [DW-1:0] xwd, input logic dn, er, input logic [DW-1:0] rd);
    vec_t t;
    t.tr = tr; t.rw = rw; t.wa = wa; t.wd = wd; t.ra = ra;
    t.r1 = r1; t.r2 = r2; t.e1 = e1; t.e2 = e2; t.d1 = d1; t.d2 = d2;
    t.x_s1 = s1; t.x_s2 = s2; t.x_en = en; t.x_pa = pa; t.x_pw = pw;
    t.x_wd = xwd; t.x_dn = dn; t.x_er = er; t.x_rd = rd;
    return t;
  endfunction

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic s1, s2, en,
                          input logic [AW-1:0] pa, input logic pw,
                          input logic [DW-1:0] wd, input logic dn, er,
                          input logic [DW-1:0] rd);
    chk({tag, "_psel1"},   32'(bus.psel1),         32'(s1));
    chk({tag, "_psel2"},   32'(bus.psel2),         32'(s2));
    chk({tag, "_penable"}, 32'(bus.penable),       32'(en));
    chk({tag, "_paddr"},   32'(bus.paddr),         32'(pa));
    chk({tag, "_pwrite"},  32'(bus.pwrite),        32'(pw));
    chk({tag, "_pwdata"},  32'(bus.pwdata),        32'(wd));
    chk({tag, "_done"},    32'(transfer_done),     32'(dn));
    chk({tag, "_err"},     32'(pslverr_out),       32'(er));
    chk({tag, "_rdata"},   32'(apb_read_data_out), 32'(rd));
  endtask

  task automatic drive(input vec_t t);
    transfer        = t.tr;
    read_write      = t.rw;
    apb_write_paddr = t.wa;
    apb_write_data  = t.wd;
    apb_read_paddr  = t.ra;
    bus.pready1     = t.r1;
    bus.pready2     = t.r2;
    bus.pslverr1    = t.e1;
    bus.pslverr2    = t.e2;
    bus.prdata1     = t.d1;
    bus.prdata2     = t.d2;
  endtask

  initial begin
    int n;

    //   tr rw wa      wd     ra      r1 r2 e1 e2 d1     d2      s1 s2 en pa      pw wd     dn er rd
    // write 0x0A5 <- 0x3C to slave1, zero wait
    vecs.push_back(v(1, 0, 9'h0A5, 8'h3C, 9'h000, 1, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 9'h0A5, 1, 8'h3C, 0, 0, 8'h00));
    vecs.push_back(v(0, 0, 9'h0A5, 8'h3C, 9'h000, 1, 0, 0, 0, 8'h00, 8'h00, 1, 0, 1, 9'h0A5, 1, 8'h3C, 0, 0, 8'h00));
    vecs.push_back(v(0, 0, 9'h0A5, 8'h3C, 9'h000, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 9'h0A5, 1, 8'h3C, 1, 0, 8'h00));
    vecs.push_back(v(0, 0, 9'h0A5, 8'h3C, 9'h000, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 9'h0A5, 1, 8'h3C, 0, 0, 8'h00));
    // read 0x105 from slave2, two wait states; slave1 lines active but ignored
    vecs.push_back(v(1, 1, 9'h1FF, 8'hEE, 9'h105, 1, 0, 1, 0, 8'h77, 8'h00, 0, 1, 0, 9'h105, 0, 8'h3C, 0, 0, 8'h00));
    vecs.push_back(v(0, 1, 9'h1FF, 8'hEE, 9'h105, 1, 0, 1, 0, 8'h77, 8'h00, 0, 1, 1, 9'h105, 0, 8'h3C, 0, 0, 8'h00));
    vecs.push_back(v(0, 1, 9'h1FF, 8'hEE, 9'h105, 1, 0, 1, 0, 8'h77, 8'h00, 0, 1, 1, 9'h105, 0, 8'h3C, 0, 0, 8'h00));
    vecs.push_back(v(0, 1, 9'h1FF, 8'hEE, 9'h105, 1, 0, 1, 0, 8'h77, 8'h00, 0, 1, 1, 9'h105, 0, 8'h3C, 0, 0, 8'h00));
    vecs.push_back(v(0, 1, 9'h1FF, 8'hEE, 9'h105, 1, 1, 1, 0, 8'h77, 8'hC3, 0, 0, 0, 9'h105, 0, 8'h3C, 1, 0, 8'hC3));
    vecs.push_back(v(0, 1, 9'h1FF, 8'hEE, 9'h105, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 9'h105, 0, 8'h3C, 0, 0, 8'hC3));
    // back-to-back: write 0x010 <- 0x11 then read 0x110, transfer held high
    vecs.push_back(v(1, 0, 9'h010, 8'h11, 9'h110, 1, 1, 0, 0, 8'h00, 8'h5A, 1, 0, 0, 9'h010, 1, 8'h11, 0, 0, 8'hC3));
    vecs.push_back(v(1, 1, 9'h010, 8'h11, 9'h110, 1, 1, 0, 0, 8'h00, 8'h5A, 1, 0, 1, 9'h010, 1, 8'h11, 0, 0, 8'hC3));
    vecs.push_back(v(1, 1, 9'h010, 8'h11, 9'h110, 1, 1, 0, 0, 8'h00, 8'h5A, 0, 1, 0, 9'h110, 0, 8'h11, 1, 0, 8'hC3));
    vecs.push_back(v(0, 1, 9'h010, 8'h11, 9'h110, 1, 1, 0, 0, 8'h00, 8'h5A, 0, 1, 1, 9'h110, 0, 8'h11, 0, 0, 8'hC3));
    vecs.push_back(v(0, 1, 9'h010, 8'h11, 9'h110, 1, 1, 0, 0, 8'h00, 8'h5A, 0, 0, 0, 9'h110, 0, 8'h11, 1, 0, 8'h5A));
    vecs.push_back(v(0, 0, 9'h010, 8'h11, 9'h110, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 9'h110, 0, 8'h11, 0, 0, 8'h5A));
    // write with slave error, then a clean read clears the status
    vecs.push_back(v(1, 0, 9'h020, 8'h99, 9'h000, 1, 0, 1, 0, 8'h00, 8'h00, 1, 0, 0, 9'h020, 1, 8'h99, 0, 0, 8'h5A));
    vecs.push_back(v(0, 0, 9'h020, 8'h99, 9'h000, 1, 0, 1, 0, 8'h00, 8'h00, 1, 0, 1, 9'h020, 1, 8'h99, 0, 0, 8'h5A));
    vecs.push_back(v(0, 0, 9'h020, 8'h99, 9'h000, 1, 0, 1, 0, 8'h00, 8'h00, 0, 0, 0, 9'h020, 1, 8'h99, 1, 1, 8'h5A));
    vecs.push_back(v(0, 0, 9'h020, 8'h99, 9'h000, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 9'h020, 1, 8'h99, 0, 1, 8'h5A));
    vecs.push_back(v(1, 1, 9'h020, 8'h99, 9'h033, 0, 0, 0, 0, 8'h4D, 8'h00, 1, 0, 0, 9'h033, 0, 8'h99, 0, 1, 8'h5A));
    vecs.push_back(v(0, 1, 9'h020, 8'h99, 9'h033, 0, 0, 0, 0, 8'h4D, 8'h00, 1, 0, 1, 9'h033, 0, 8'h99, 0, 1, 8'h5A));
    vecs.push_back(v(0, 1, 9'h020, 8'h99, 9'h033, 1, 0, 0, 0, 8'h4D, 8'h00, 0, 0, 0, 9'h033, 0, 8'h99, 1, 0, 8'h4D));
    // read with slave error still returns the read data
    vecs.push_back(v(1, 1, 9'h000, 8'h00, 9'h0AB, 0, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 9'h0AB, 0, 8'h99, 0, 0, 8'h4D));
    vecs.push_back(v(0, 1, 9'h000, 8'h00, 9'h0AB, 0, 0, 0, 0, 8'h00, 8'h00, 1, 0, 1, 9'h0AB, 0, 8'h99, 0, 0, 8'h4D));
    vecs.push_back(v(0, 1, 9'h000, 8'h00, 9'h0AB, 1, 0, 1, 0, 8'hE7, 8'h00, 0, 0, 0, 9'h0AB, 0, 8'h99, 1, 1, 8'hE7));

    // reset
    presetn = 1'b1;
    drive(v(0, 0, 9'h0, 8'h0, 9'h0, 0, 0, 0, 0, 8'h0, 8'h0, 0, 0, 0, 9'h0, 0, 8'h0, 0, 0, 8'h0));
    tick();
    tick();
    chk_outs("reset", 0, 0, 0, 9'h000, 0, 8'h00, 0, 0, 8'h00);
    presetn = 1'b0;
    tick();
    chk_outs("idle", 0, 0, 0, 9'h000, 0, 8'h00, 0, 0, 8'h00);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      tick();
      chk_outs($sformatf("row%0d", i), vecs[i].x_s1, vecs[i].x_s2, vecs[i].x_en,
               vecs[i].x_pa, vecs[i].x_pw, vecs[i].x_wd, vecs[i].x_dn,
               vecs[i].x_er, vecs[i].x_rd);
    end

    // timeout: slave1 never ready, slave2 ready but unselected
    transfer = 1'b1; read_write = 1'b1; apb_read_paddr = 9'h044;
    bus.pready1 = 1'b0; bus.pready2 = 1'b1; bus.pslverr1 = 1'b0; bus.pslverr2 = 1'b0;
    bus.prdata1 = 8'hAA; bus.prdata2 = 8'hBB;
    tick();
    chk("to_setup_psel1", 32'(bus.psel1), 32'd1);
    transfer = 1'b0;
    tick();
    chk("to_access_penable", 32'(bus.penable), 32'd1);
    n = 0;
    while (transfer_done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("to_access_cycles", 32'(n), 32'(TIMEOUT));
    chk("to_err", 32'(pslverr_out), 32'd1);
    chk("to_rdata_kept", 32'(apb_read_data_out), 32'hE7);
    chk("to_psel1_idle", 32'(bus.psel1), 32'd0);
    tick();
    chk("to_done_single", 32'(transfer_done), 32'd0);

    // reset during ACCESS aborts the transfer
    transfer = 1'b1; read_write = 1'b0; apb_write_paddr = 9'h150; apb_write_data = 8'h66;
    bus.pready2 = 1'b0;
    tick();
    transfer = 1'b0;
    tick();
    chk("rst_pre_penable", 32'(bus.penable), 32'd1);
    chk("rst_pre_psel2", 32'(bus.psel2), 32'd1);
    presetn = 1'b1;
    bus.pready2 = 1'b1;
    tick();
    chk_outs("rst_mid", 0, 0, 0, 9'h000, 0, 8'h00, 0, 0, 8'h00);
    presetn = 1'b0;
    tick();
    chk("rst_after_done", 32'(transfer_done), 32'd0);
    chk("rst_after_psel2", 32'(bus.psel2), 32'd0);

    // normal transfer after reset
    transfer = 1'b1; read_write = 1'b1; apb_read_paddr = 9'h1AB;
    bus.prdata2 = 8'h21; bus.pready2 = 1'b1;
    tick();
    chk_outs("post_setup", 0, 1, 0, 9'h1AB, 0, 8'h00, 0, 0, 8'h00);
    transfer = 1'b0;
    tick();
    chk_outs("post_access", 0, 1, 1, 9'h1AB, 0, 8'h00, 0, 0, 8'h00);
    tick();
    chk_outs("post_done", 0, 0, 0, 9'h1AB, 0, 8'h00, 1, 0, 8'h21);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- APB master FSM directly downstream of the testbench-facing request interface (transfer, read_write, apb_write_paddr, apb_write_data, apb_read_paddr, apb_read_data_out).
- Turns each requested transfer into a standard APB SETUP/ACCESS sequence toward two slaves, selected by address MSB.
- Returns read data and transfer status to the requester.
- Adds a per-transfer wait-state timeout so a hung slave cannot stall the bus.

Parameters:
- AW, 9, address width; bit AW-1 selects the slave (0 = slave1, 1 = slave2).
- DW, 8, data width.
- TIMEOUT, 16, max ACCESS cycles without PREADY before forced error completion (>=2).

Ports:
- pclk  in  1  APB clock; all logic on rising edge.
- presetn  in  1  reset, synchronous active-high (1 = reset). The name follows codebase convention; the polarity is fixed active-high.
- transfer  in  1  request strobe; level, sampled when the FSM can accept.
- read_write  in  1  1 = read, 0 = write.
- apb_write_paddr  in  AW  write address.
- apb_write_data  in  DW  write data.
- apb_read_paddr  in  AW  read address.
- apb_read_data_out  out  DW  last completed read data (registered).
- transfer_done  out  1  one-cycle pulse on completion of any transfer.
- pslverr_out  out  1  status of last completed transfer; 1 = slave error or timeout.
- psel1 / psel2  out  1  slave selects.
- penable  out  1  APB enable.
- paddr  out  AW  APB address.
- pwrite  out  1  APB direction.
- pwdata  out  DW  APB write data.
- prdata1 / prdata2  in  DW  slave read data.
- pready1 / pready2  in  1  slave ready.
- pslverr1 / pslverr2  in  1  slave error.

Behaviour:
- Reset (presetn = 1 at a rising edge), effective after that edge:
  - FSM returns to IDLE.
  - psel1, psel2, penable, pwrite, transfer_done and pslverr_out are 0.
  - paddr, pwdata and apb_read_data_out are 0.
  - Wait counter is 0.
  - Reset mid-SETUP or mid-ACCESS aborts the transfer: no transfer_done pulse and no read-data update.
- All outputs are registered.
- States: IDLE, SETUP, ACCESS.
- IDLE:
  - transfer = 0: stay in IDLE; psel and penable are 0.
  - transfer = 1: capture the request and go to SETUP.
    - pwrite <= ~read_write.
    - paddr <= read_write ? apb_read_paddr : apb_write_paddr.
    - pwdata <= apb_write_data on a write; pwdata holds its old value on a read.
    - psel1 <= ~addr[AW-1]; psel2 <= addr[AW-1].
    - penable <= 0.
- SETUP: unconditionally go to ACCESS; penable <= 1; wait counter <= 0.
- ACCESS: only the selected slave's pready, prdata and pslverr are used; unselected inputs are ignored.
  - Selected pready = 1 completes the transfer:
    - transfer_done <= 1.
    - pslverr_out <= selected pslverr.
    - On a read, apb_read_data_out <= selected prdata, regardless of pslverr.
  - Selected pready = 0:
    - If counter < TIMEOUT-1, counter increments and state holds.
    - If counter = TIMEOUT-1, force completion: transfer_done <= 1, pslverr_out <= 1, apb_read_data_out unchanged.
  - On completion with transfer = 1: capture a new request as in IDLE and go directly to SETUP (back-to-back, psel recomputed, penable <= 0).
  - On completion with transfer = 0: go to IDLE; psel <= 0, penable <= 0.
- During SETUP and ACCESS, paddr, pwrite, pwdata and psel are stable; transfer and request-input changes are ignored.
- Latency:
  - transfer sampled at edge N gives SETUP after N, ACCESS after N+1.
  - Zero-wait completion at edge N+2; read data and transfer_done are visible after N+2.
  - Minimum 2 cycles per transfer; sustained back-to-back throughput is one transfer per 2 cycles.
- transfer_done is high for exactly one cycle per completion and never while in IDLE without a completion.
- pslverr_out holds until the next completion overwrites it.

Test Plan:
- Reset, then write: AW=9, DW=8; write 0x0A5 data 0x3C with pready1=1 → psel1 high for 2 cycles, penable in cycle 2, paddr=0x0A5, pwrite=1, pwdata=0x3C, transfer_done pulse at N+2, pslverr_out=0.
- Read slave2: read 0x105, pready2 low for 2 ACCESS cycles, prdata2=0xC3 → psel2=1, psel1=0, ACCESS lasts 3 cycles, apb_read_data_out=0xC3 after completion, one transfer_done pulse.
- Back-to-back: transfer held high across write 0x010/0x11 then read 0x110 → psel1 drops and psel2 rises at SETUP, no IDLE cycle, two done pulses 2 cycles apart.
- Timeout: TIMEOUT=16, read slave1 with pready1 stuck 0 and pready2=1 → completion after exactly 16 ACCESS cycles, pslverr_out=1, apb_read_data_out unchanged, pready2 ignored.
- Slave error: write with pready1=1 and pslverr1=1 → pslverr_out=1. The next clean transfer clears it to 0.
- Reset mid-ACCESS: assert presetn during ACCESS → next cycle all outputs 0, no done pulse. A transfer issued afterwards completes normally.
